// File: rtl/dsram_axi_bridge_if.sv
// AXI4-Lite channel bundle between the data-SRAM bridge (master) and its slave.
// Valid/payload signals are driven by the master, ready/response signals by the slave.
interface dsram_axi_bridge_if #(
  parameter int ADDR_WD = 64,
  parameter int DATA_WD = 64
);
  localparam int WEN_WD = DATA_WD / 8;

  logic               awvalid;
  logic               awready;
  logic [ADDR_WD-1:0] awaddr;
  logic [2:0]         awprot;

  logic               wvalid;
  logic               wready;
  logic [DATA_WD-1:0] wdata;
  logic [WEN_WD-1:0]  wstrb;

  logic               bvalid;
  logic               bready;
  logic [1:0]         bresp;

  logic               arvalid;
  logic               arready;
  logic [ADDR_WD-1:0] araddr;
  logic [2:0]         arprot;

  logic               rvalid;
  logic               rready;
  logic [DATA_WD-1:0] rdata;
  logic [1:0]         rresp;

  modport master (
    output awvalid, awaddr, awprot,
    input  awready,
    output wvalid, wdata, wstrb,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arprot,
    input  arready,
    input  rvalid, rdata, rresp,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    output awready,
    input  wvalid, wdata, wstrb,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arprot,
    output arready,
    output rvalid, rdata, rresp,
    input  rready
  );
endinterface

// File: rtl/dsram_axi_bridge.sv
// Converts single core data-SRAM requests into AXI4-Lite transactions, one at a time,
// and returns read data or a write acknowledge as a one-cycle sram_rvalid pulse.
module dsram_axi_bridge #(
  parameter int ADDR_WD = 64,
  parameter int DATA_WD = 64,
  parameter int WEN_WD  = DATA_WD / 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sram_en,
  input  logic [WEN_WD-1:0]  sram_wen,
  input  logic [ADDR_WD-1:0] sram_addr,
  input  logic [DATA_WD-1:0] sram_wdata,
  output logic               sram_ready,
  output logic               sram_rvalid,
  output logic [DATA_WD-1:0] sram_rdata,
  output logic               resp_err,
  dsram_axi_bridge_if.master axi
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } state_t;

  state_t             state_reg, state_next;
  logic [ADDR_WD-1:0] addr_reg, addr_next;
  logic [DATA_WD-1:0] wdata_reg, wdata_next;
  logic [WEN_WD-1:0]  strb_reg, strb_next;
  logic               aw_pend_reg, aw_pend_next;
  logic               w_pend_reg, w_pend_next;
  logic               arvalid_reg, arvalid_next;
  logic               rready_reg, rready_next;
  logic               awvalid_reg, awvalid_next;
  logic               wvalid_reg, wvalid_next;
  logic               bready_reg, bready_next;
  logic               sram_rvalid_reg, sram_rvalid_next;
  logic [DATA_WD-1:0] sram_rdata_reg, sram_rdata_next;
  logic               resp_err_reg, resp_err_next;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign ar_hs = arvalid_reg & axi.arready;
  assign r_hs  = rready_reg  & axi.rvalid;
  assign aw_hs = awvalid_reg & axi.awready;
  assign w_hs  = wvalid_reg  & axi.wready;
  assign b_hs  = bready_reg  & axi.bvalid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      strb_reg        <= '0;
      aw_pend_reg     <= 1'b0;
      w_pend_reg      <= 1'b0;
      arvalid_reg     <= 1'b0;
      rready_reg      <= 1'b0;
      awvalid_reg     <= 1'b0;
      wvalid_reg      <= 1'b0;
      bready_reg      <= 1'b0;
      sram_rvalid_reg <= 1'b0;
      sram_rdata_reg  <= '0;
      resp_err_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      addr_reg        <= addr_next;
      wdata_reg       <= wdata_next;
      strb_reg        <= strb_next;
      aw_pend_reg     <= aw_pend_next;
      w_pend_reg      <= w_pend_next;
      arvalid_reg     <= arvalid_next;
      rready_reg      <= rready_next;
      awvalid_reg     <= awvalid_next;
      wvalid_reg      <= wvalid_next;
      bready_reg      <= bready_next;
      sram_rvalid_reg <= sram_rvalid_next;
      sram_rdata_reg  <= sram_rdata_next;
      resp_err_reg    <= resp_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    addr_next        = addr_reg;
    wdata_next       = wdata_reg;
    strb_next        = strb_reg;
    aw_pend_next     = aw_pend_reg;
    w_pend_next      = w_pend_reg;
    sram_rvalid_next = 1'b0;
    sram_rdata_next  = sram_rdata_reg;
    resp_err_next    = resp_err_reg;

    case (state_reg)
      IDLE: begin
        if (sram_en) begin
          addr_next  = sram_addr;
          wdata_next = sram_wdata;
          strb_next  = sram_wen;
          if (sram_wen == '0) begin
            state_next = RD_ADDR;
          end else begin
            state_next   = WR_REQ;
            aw_pend_next = 1'b1;
            w_pend_next  = 1'b1;
          end
        end
      end
      RD_ADDR: begin
        if (ar_hs) state_next = RD_DATA;
      end
      RD_DATA: begin
        if (r_hs) begin
          sram_rdata_next  = axi.rdata;
          resp_err_next    = resp_err_reg | (axi.rresp != 2'b00);
          sram_rvalid_next = 1'b1;
          state_next       = IDLE;
        end
      end
      WR_REQ: begin
        // AW and W retire independently; leave once neither is outstanding.
        if (aw_hs) aw_pend_next = 1'b0;
        if (w_hs)  w_pend_next  = 1'b0;
        if (!aw_pend_next && !w_pend_next) state_next = WR_RESP;
      end
      WR_RESP: begin
        if (b_hs) begin
          resp_err_next    = resp_err_reg | (axi.bresp != 2'b00);
          sram_rvalid_next = 1'b1;
          state_next       = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Channel controls are registered copies of the upcoming state, so no valid is
  // ever a combinational function of the matching ready.
  assign arvalid_next = (state_next == RD_ADDR);
  assign rready_next  = (state_next == RD_DATA);
  assign awvalid_next = (state_next == WR_REQ) & aw_pend_next;
  assign wvalid_next  = (state_next == WR_REQ) & w_pend_next;
  assign bready_next  = (state_next == WR_RESP);

  assign sram_ready  = (state_reg == IDLE);
  assign sram_rvalid = sram_rvalid_reg;
  assign sram_rdata  = sram_rdata_reg;
  assign resp_err    = resp_err_reg;

  assign axi.awvalid = awvalid_reg;
  assign axi.awaddr  = addr_reg;
  assign axi.awprot  = 3'b000;
  assign axi.wvalid  = wvalid_reg;
  assign axi.wdata   = wdata_reg;
  assign axi.wstrb   = strb_reg;
  assign axi.bready  = bready_reg;
  assign axi.arvalid = arvalid_reg;
  assign axi.araddr  = addr_reg;
  assign axi.arprot  = 3'b000;
  assign axi.rready  = rready_reg;

endmodule

// File: tb/tb_dsram_axi_bridge.sv
// Scoreboard bench for dsram_axi_bridge: directed requests against a configurable
// AXI4-Lite slave model; a negedge monitor checks every AXI beat and completion pulse.
module tb_dsram_axi_bridge;

  logic        clk;
  logic        reset;
  logic        sram_en;
  logic [7:0]  sram_wen;
  logic [63:0] sram_addr;
  logic [63:0] sram_wdata;
  logic        sram_ready;
  logic        sram_rvalid;
  logic [63:0] sram_rdata;
  logic        resp_err;

  dsram_axi_bridge_if #(.ADDR_WD(64), .DATA_WD(64)) axi ();

  dsram_axi_bridge #(.ADDR_WD(64), .DATA_WD(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .sram_en    (sram_en),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_ready (sram_ready),
    .sram_rvalid(sram_rvalid),
    .sram_rdata (sram_rdata),
    .resp_err   (resp_err),
    .axi        (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- slave model ----------------
  int          aw_delay = 0;
  int          w_delay  = 0;
  int          r_delay  = 0;
  logic [63:0] rd_data_cfg = '0;
  logic [1:0]  rresp_cfg = 2'b00;
  logic [1:0]  bresp_cfg = 2'b00;

  int   aw_cnt, w_cnt, r_cnt;
  logic got_aw, got_w, r_pend;
  logic aw_hs, w_hs;

  assign axi.awready = axi.awvalid && (aw_cnt >= aw_delay);
  assign axi.wready  = axi.wvalid  && (w_cnt  >= w_delay);
  assign axi.arready = axi.arvalid;
  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs  = axi.wvalid  && axi.wready;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      axi.rvalid <= 1'b0;
      axi.rdata  <= '0;
      axi.rresp  <= 2'b00;
      axi.bvalid <= 1'b0;
      axi.bresp  <= 2'b00;
      aw_cnt <= 0;
      w_cnt  <= 0;
      r_cnt  <= 0;
      got_aw <= 1'b0;
      got_w  <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      if (axi.awvalid) aw_cnt <= aw_hs ? 0 : aw_cnt + 1;
      if (axi.wvalid)  w_cnt  <= w_hs  ? 0 : w_cnt + 1;
      if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
      if (axi.arvalid && axi.arready) begin
        axi.rdata <= rd_data_cfg;
        axi.rresp <= rresp_cfg;
        if (r_delay == 0) axi.rvalid <= 1'b1;
        else begin
          r_pend <= 1'b1;
          r_cnt  <= r_delay - 1;
        end
      end else if (r_pend) begin
        if (r_cnt == 0) begin
          axi.rvalid <= 1'b1;
          r_pend     <= 1'b0;
        end else r_cnt <= r_cnt - 1;
      end
      if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
      if ((got_aw || aw_hs) && (got_w || w_hs)) begin
        axi.bvalid <= 1'b1;
        axi.bresp  <= bresp_cfg;
        got_aw <= 1'b0;
        got_w  <= 1'b0;
      end else begin
        got_aw <= got_aw || aw_hs;
        got_w  <= got_w  || w_hs;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          is_wr;
    logic [63:0] rdata;
    int          exp_cyc;
  } sb_t;
  typedef struct {
    logic [63:0] data;
    logic [7:0]  strb;
  } wr_t;

  sb_t         sb_q[$];
  logic [63:0] ar_q[$];
  logic [63:0] aw_q[$];
  wr_t         w_q[$];

  int   last_r_cyc = -10;
  int   last_b_cyc = -10;
  int   b_cnt = 0;
  logic p_aw_hs, p_awvalid, p_w_hs, p_wvalid, p_ar_hs, p_arvalid, p_srv;

  always @(negedge clk) begin
    sb_t e;
    wr_t w;
    if (!reset) begin
      p_aw_hs = 0; p_awvalid = 0; p_w_hs = 0; p_wvalid = 0;
      p_ar_hs = 0; p_arvalid = 0; p_srv = 0;
    end else begin
      if (p_srv) chk("rvalid_pulse", 64'(sram_rvalid), 64'd0);
      if (sram_rvalid) begin
        chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk(e.is_wr ? "wr_ack_rdata" : "rd_rdata", sram_rdata, e.rdata);
          chk("rvalid_after_resp", 64'(cyc), 64'((e.is_wr ? last_b_cyc : last_r_cyc) + 1));
          if (e.exp_cyc >= 0) chk("rvalid_latency", 64'(cyc), 64'(e.exp_cyc));
        end
      end
      if (axi.arvalid && axi.arready) begin
        chk("ar_expected", 64'(ar_q.size() != 0), 64'd1);
        if (ar_q.size() != 0) chk("araddr", axi.araddr, ar_q.pop_front());
        chk("arprot", 64'(axi.arprot), 64'd0);
      end
      if (aw_hs) begin
        chk("aw_expected", 64'(aw_q.size() != 0), 64'd1);
        if (aw_q.size() != 0) chk("awaddr", axi.awaddr, aw_q.pop_front());
        chk("awprot", 64'(axi.awprot), 64'd0);
      end
      if (w_hs) begin
        chk("w_expected", 64'(w_q.size() != 0), 64'd1);
        if (w_q.size() != 0) begin
          w = w_q.pop_front();
          chk("wdata", axi.wdata, w.data);
          chk("wstrb", 64'(axi.wstrb), 64'(w.strb));
        end
      end
      if (axi.rvalid && axi.rready) last_r_cyc = cyc;
      if (axi.bvalid && axi.bready) begin
        last_b_cyc = cyc;
        b_cnt++;
      end
      if (p_aw_hs) chk("awvalid_drop", 64'(axi.awvalid), 64'd0);
      else if (p_awvalid) chk("awvalid_hold", 64'(axi.awvalid), 64'd1);
      if (p_w_hs) chk("wvalid_drop", 64'(axi.wvalid), 64'd0);
      else if (p_wvalid) chk("wvalid_hold", 64'(axi.wvalid), 64'd1);
      if (p_ar_hs) chk("arvalid_drop", 64'(axi.arvalid), 64'd0);
      else if (p_arvalid) chk("arvalid_hold", 64'(axi.arvalid), 64'd1);
      p_aw_hs = aw_hs;  p_awvalid = axi.awvalid;
      p_w_hs  = w_hs;   p_wvalid  = axi.wvalid;
      p_ar_hs = axi.arvalid && axi.arready;
      p_arvalid = axi.arvalid;
      p_srv = sram_rvalid;
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; returns at the negedge after the request was accepted.
  task automatic issue(input logic [7:0] wen, input logic [63:0] addr, input logic [63:0] data,
                       input logic [63:0] exp_rd, input int lat, input bit hold, output int acc);
    int  n;
    sb_t e;
    wr_t w;
    sram_en = 1'b1;
    sram_wen = wen;
    sram_addr = addr;
    sram_wdata = data;
    n = 0;
    while (!sram_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", 64'(n < 200), 64'd1);
    acc = cyc;
    e.is_wr = (wen != 0);
    e.rdata = exp_rd;
    e.exp_cyc = (lat < 0) ? -1 : cyc + lat;
    sb_q.push_back(e);
    if (wen == 0) ar_q.push_back(addr);
    else begin
      aw_q.push_back(addr);
      w.data = data;
      w.strb = wen;
      w_q.push_back(w);
    end
    @(negedge clk);
    if (!hold) sram_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || ar_q.size() != 0 || aw_q.size() != 0 || w_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", 64'(n < 300), 64'd1);
  endtask

  initial begin
    int acc, acc2, n;
    logic [63:0] last_rd;
    reset = 1'b0;
    sram_en = 1'b0;
    sram_wen = '0;
    sram_addr = '0;
    sram_wdata = '0;
    repeat (3) @(negedge clk);

    chk("rst_sram_ready", 64'(sram_ready), 64'd1);
    chk("rst_sram_rvalid", 64'(sram_rvalid), 64'd0);
    chk("rst_sram_rdata", sram_rdata, 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_axi_ctrl", 64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1: zero-wait read, ready low for two cycles after accept
    rd_data_cfg = 64'hDEAD_BEEF_0123_4567;
    issue(8'h00, 64'h8000_0010, 64'd0, 64'hDEAD_BEEF_0123_4567, 3, 0, acc);
    chk("t1_ready_T1", 64'(sram_ready), 64'd0);
    @(negedge clk);
    chk("t1_ready_T2", 64'(sram_ready), 64'd0);
    @(negedge clk);
    chk("t1_ready_T3", 64'(sram_ready), 64'd1);
    drain();
    last_rd = 64'hDEAD_BEEF_0123_4567;

    // 2: partial-strobe write, zero-wait
    issue(8'h0F, 64'h8000_0020, 64'h1122_3344_5566_7788, last_rd, 3, 0, acc);
    drain();

    // 3: W before AW, then AW before W
    aw_delay = 3;
    w_delay = 0;
    issue(8'hFF, 64'h8000_0030, 64'hCAFE_F00D_0000_0001, last_rd, 6, 0, acc);
    drain();
    aw_delay = 0;
    w_delay = 3;
    issue(8'hF0, 64'h8000_0038, 64'hCAFE_F00D_0000_0002, last_rd, 6, 0, acc);
    drain();
    w_delay = 0;
    chk("t3_resp_err_clean", 64'(resp_err), 64'd0);

    // 4: SLVERR on a read is sticky across later OKAY traffic
    rresp_cfg = 2'b10;
    rd_data_cfg = 64'h0BAD_0BAD_5555_AAAA;
    issue(8'h00, 64'h8000_0040, 64'd0, 64'h0BAD_0BAD_5555_AAAA, 3, 0, acc);
    drain();
    last_rd = 64'h0BAD_0BAD_5555_AAAA;
    rresp_cfg = 2'b00;
    chk("t4_resp_err_set", 64'(resp_err), 64'd1);
    issue(8'h81, 64'h8000_0043, 64'hA5A5_5A5A_A5A5_5A5A, last_rd, 3, 0, acc);
    drain();
    rd_data_cfg = 64'h0123_4567_89AB_CDEF;
    issue(8'h00, 64'h8000_0048, 64'd0, 64'h0123_4567_89AB_CDEF, 3, 0, acc);
    drain();
    last_rd = 64'h0123_4567_89AB_CDEF;
    chk("t4_resp_err_sticky", 64'(resp_err), 64'd1);

    // 5: asynchronous reset while waiting for read data
    r_delay = 10;
    rd_data_cfg = 64'h7777_7777_7777_7777;
    issue(8'h00, 64'h8000_0050, 64'd0, 64'd0, -1, 0, acc);
    n = 0;
    while (!axi.rready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_rd_data", 64'(axi.rready), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("t5_axi_ctrl_low", 64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 64'd0);
    chk("t5_sram_rvalid", 64'(sram_rvalid), 64'd0);
    chk("t5_resp_err_clr", 64'(resp_err), 64'd0);
    chk("t5_sram_rdata_clr", sram_rdata, 64'd0);
    sb_q.delete();
    ar_q.delete();
    aw_q.delete();
    w_q.delete();
    @(negedge clk);
    reset = 1'b1;
    r_delay = 0;
    @(negedge clk);
    chk("t5_ready_after_rst", 64'(sram_ready), 64'd1);

    // 6: read then write with sram_en held; write taken in the read's rvalid cycle
    rd_data_cfg = 64'hFEED_FACE_1234_5678;
    issue(8'h00, 64'h8000_0060, 64'd0, 64'hFEED_FACE_1234_5678, 3, 1, acc);
    issue(8'h3C, 64'h8000_0068, 64'h0F0F_0F0F_F0F0_F0F0, 64'hFEED_FACE_1234_5678, 3, 0, acc2);
    chk("t6_back_to_back", 64'(acc2), 64'(acc + 3));
    drain();
    repeat (3) @(negedge clk);

    chk("b_handshakes", 64'(b_cnt), 64'd5);
    chk("resp_err_final", 64'(resp_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
